// File: rtl/ub_write_scheduler_pkg.sv
// Shared types and sizing for the unified-buffer write scheduler.
// The FSM state enum and default geometry live here so every file agrees on them.
package ub_write_scheduler_pkg;

  localparam int unsigned UB_DEPTH  = 64;
  localparam int unsigned UB_DATA_W = 32;
  localparam int unsigned UB_ADDR_W = $clog2(UB_DEPTH);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWr0  = 2'd1,
    StWr1  = 2'd2
  } ub_state_e;

endpackage

// File: rtl/ub_write_scheduler_if.sv
// Request/ack and unified-buffer write bus of the write scheduler.
// master = accumulator/requester side, slave = the scheduler.
interface ub_write_scheduler_if
  import ub_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH  = UB_DEPTH,
  parameter int unsigned DATA_W = UB_DATA_W
) ();

  localparam int unsigned AddrW = $clog2(DEPTH);

  logic              store_acc1;
  logic              store_acc2;
  logic [DATA_W-1:0] acc1_mem_0;
  logic [DATA_W-1:0] acc1_mem_1;
  logic [DATA_W-1:0] acc2_mem_0;
  logic [DATA_W-1:0] acc2_mem_1;
  logic              clear_ptr;
  logic              acc1_ack;
  logic              acc2_ack;
  logic              ub_wr_en;
  logic [AddrW-1:0]  ub_wr_addr;
  logic [DATA_W-1:0] ub_wr_data;
  logic              ub_full;
  logic [AddrW:0]    words_written;

  modport master (
    output store_acc1, store_acc2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1, clear_ptr,
    input  acc1_ack, acc2_ack, ub_wr_en, ub_wr_addr, ub_wr_data, ub_full, words_written
  );

  modport slave (
    input  store_acc1, store_acc2, acc1_mem_0, acc1_mem_1, acc2_mem_0, acc2_mem_1, clear_ptr,
    output acc1_ack, acc2_ack, ub_wr_en, ub_wr_addr, ub_wr_data, ub_full, words_written
  );

endinterface

// File: rtl/ub_write_scheduler_rr_arbiter.sv
// Two-requester round-robin arbiter; last_grant names the previous winner (0=acc1, 1=acc2).
// Grants are combinational and only issued while en_i is high.
module ub_rr_arbiter (
  input  logic clk,
  input  logic reset,
  input  logic req1_i,
  input  logic req2_i,
  input  logic en_i,
  output logic gnt1_o,
  output logic gnt2_o
);

  logic last_q, last_d;

  always_comb begin
    // On a tie the requester not named by last_grant wins.
    gnt1_o = en_i && req1_i && (!req2_i || last_q);
    gnt2_o = en_i && req2_i && (!req1_i || !last_q);
    last_d = last_q;
    if (gnt1_o) begin
      last_d = 1'b0;
    end else if (gnt2_o) begin
      last_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/ub_write_scheduler.sv
// Serialises two-word accumulator stores into the unified buffer, one burst per grant.
// Tracks the write pointer and a saturating fill count; clear_ptr never splits a burst.
module ub_write_scheduler
  import ub_write_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH  = UB_DEPTH,
  parameter int unsigned DATA_W = UB_DATA_W
) (
  input logic                 clk,
  input logic                 reset,
  ub_write_scheduler_if.slave bus
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam logic [CntW-1:0] DepthC     = CntW'(DEPTH);
  localparam logic [CntW-1:0] FullThresh = CntW'(DEPTH - 2);
  localparam logic [CntW-1:0] Two        = CntW'(2);

  ub_state_e         state_q, state_d;
  logic [AddrW-1:0]  wptr_q, wptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [DATA_W-1:0] hold0_q, hold0_d;
  logic [DATA_W-1:0] hold1_q, hold1_d;
  logic [AddrW-1:0]  last_addr_q, last_addr_d;
  logic [DATA_W-1:0] last_data_q, last_data_d;
  logic              ack1_q, ack1_d;
  logic              ack2_q, ack2_d;
  logic              clr_pend_q, clr_pend_d;

  logic            clear_now;
  logic [CntW-1:0] count_eff;
  logic            grant_en;
  logic            gnt1, gnt2;

  // A clear in IDLE lands before the eligibility test, so a full buffer can grant on that edge.
  assign clear_now = (state_q == StIdle) && bus.clear_ptr;
  assign count_eff = clear_now ? '0 : count_q;
  assign grant_en  = (state_q == StIdle) && (count_eff <= FullThresh);

  ub_rr_arbiter u_arb (
    .clk    (clk),
    .reset  (reset),
    .req1_i (bus.store_acc1),
    .req2_i (bus.store_acc2),
    .en_i   (grant_en),
    .gnt1_o (gnt1),
    .gnt2_o (gnt2)
  );

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    count_d     = count_q;
    hold0_d     = hold0_q;
    hold1_d     = hold1_q;
    last_addr_d = last_addr_q;
    last_data_d = last_data_q;
    clr_pend_d  = clr_pend_q;
    ack1_d      = 1'b0;
    ack2_d      = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (clear_now) begin
          wptr_d  = '0;
          count_d = '0;
        end
        if (gnt1 || gnt2) begin
          state_d = StWr0;
          ack1_d  = gnt1;
          ack2_d  = gnt2;
          hold0_d = gnt1 ? bus.acc1_mem_0 : bus.acc2_mem_0;
          hold1_d = gnt1 ? bus.acc1_mem_1 : bus.acc2_mem_1;
        end
      end
      StWr0: begin
        state_d     = StWr1;
        wptr_d      = wptr_q + AddrW'(1);
        last_addr_d = wptr_q;
        last_data_d = hold0_q;
        if (bus.clear_ptr) begin
          clr_pend_d = 1'b1;
        end
      end
      StWr1: begin
        state_d     = StIdle;
        last_addr_d = wptr_q;
        last_data_d = hold1_q;
        // A deferred clear replaces the post-burst pointer/count update.
        if (clr_pend_q || bus.clear_ptr) begin
          wptr_d     = '0;
          count_d    = '0;
          clr_pend_d = 1'b0;
        end else begin
          wptr_d  = wptr_q + AddrW'(1);
          count_d = (count_q >= DepthC - Two) ? DepthC : count_q + Two;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      wptr_q      <= '0;
      count_q     <= '0;
      hold0_q     <= '0;
      hold1_q     <= '0;
      last_addr_q <= '0;
      last_data_q <= '0;
      ack1_q      <= 1'b0;
      ack2_q      <= 1'b0;
      clr_pend_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      count_q     <= count_d;
      hold0_q     <= hold0_d;
      hold1_q     <= hold1_d;
      last_addr_q <= last_addr_d;
      last_data_q <= last_data_d;
      ack1_q      <= ack1_d;
      ack2_q      <= ack2_d;
      clr_pend_q  <= clr_pend_d;
    end
  end

  always_comb begin
    bus.ub_wr_en   = 1'b0;
    bus.ub_wr_addr = last_addr_q;
    bus.ub_wr_data = last_data_q;
    unique case (state_q)
      StWr0: begin
        bus.ub_wr_en   = 1'b1;
        bus.ub_wr_addr = wptr_q;
        bus.ub_wr_data = hold0_q;
      end
      StWr1: begin
        bus.ub_wr_en   = 1'b1;
        bus.ub_wr_addr = wptr_q;
        bus.ub_wr_data = hold1_q;
      end
      default: begin
        bus.ub_wr_en = 1'b0;
      end
    endcase
  end

  assign bus.acc1_ack      = ack1_q;
  assign bus.acc2_ack      = ack2_q;
  assign bus.ub_full       = (count_q > FullThresh);
  assign bus.words_written = count_q;

endmodule

// File: tb/tb_ub_write_scheduler.sv
// Bench for ub_write_scheduler: table of store transactions plus hand-written corner sequences.
// Expected writes are queued when stimulus is driven and popped as the DUT writes.
module tb_ub_write_scheduler;

  logic clk;
  logic reset;

  ub_write_scheduler_if #(.DEPTH(64), .DATA_W(32)) bus ();

  ub_write_scheduler #(.DEPTH(64), .DATA_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
  } wr_t;

  typedef struct {
    bit          rst;
    bit          r1;
    bit          r2;
    logic [31:0] a0, a1, b0, b1;
    int          first;
    logic [5:0]  addr;
  } vec_t;

  wr_t  exp_q[$];
  vec_t vecs[6];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push(input logic [5:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard: every write strobe must match the oldest expected write.
  always @(negedge clk) begin
    wr_t e;
    if (bus.ub_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: addr %0d data %0h, none expected",
                 bus.ub_wr_addr, bus.ub_wr_data);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", 64'(bus.ub_wr_addr), 64'(e.addr));
        check("wr_data", 64'(bus.ub_wr_data), 64'(e.data));
      end
    end
    if (bus.acc1_ack === 1'b1 && bus.acc2_ack === 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_exclusive: both acks high, expected at most one");
    end
  end

  task automatic check_zero_outputs(input string tag);
    check({tag, "_wr_en"}, 64'(bus.ub_wr_en), 64'd0);
    check({tag, "_wr_addr"}, 64'(bus.ub_wr_addr), 64'd0);
    check({tag, "_wr_data"}, 64'(bus.ub_wr_data), 64'd0);
    check({tag, "_acks"}, 64'({bus.acc1_ack, bus.acc2_ack}), 64'd0);
    check({tag, "_full"}, 64'(bus.ub_full), 64'd0);
    check({tag, "_words"}, 64'(bus.words_written), 64'd0);
  endtask

  task automatic do_reset();
    reset          = 1'b0;
    bus.store_acc1 = 1'b0;
    bus.store_acc2 = 1'b0;
    bus.clear_ptr  = 1'b0;
    bus.acc1_mem_0 = '0;
    bus.acc1_mem_1 = '0;
    bus.acc2_mem_0 = '0;
    bus.acc2_mem_1 = '0;
    tick();
    tick();
    check_zero_outputs("reset");
    exp_q.delete();
    reset = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 10) begin
      tick();
      n++;
    end
    check({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
    tick();
  endtask

  // Issue one or two requests from IDLE and check ack order/timing; writes go to the scoreboard.
  task automatic serve(input bit r1, input bit r2, input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] b0, input logic [31:0] b1, input int first,
                       input logic [5:0] addr);
    int cyc = 0;
    int n   = 0;
    bit got1 = 1'b0;
    bit got2 = 1'b0;
    if (first == 1) begin
      push(addr, a0);
      push(6'(addr + 6'd1), a1);
      if (r2) begin
        push(6'(addr + 6'd2), b0);
        push(6'(addr + 6'd3), b1);
      end
    end else begin
      push(addr, b0);
      push(6'(addr + 6'd1), b1);
      if (r1) begin
        push(6'(addr + 6'd2), a0);
        push(6'(addr + 6'd3), a1);
      end
    end
    bus.acc1_mem_0 = a0;
    bus.acc1_mem_1 = a1;
    bus.acc2_mem_0 = b0;
    bus.acc2_mem_1 = b1;
    bus.store_acc1 = r1;
    bus.store_acc2 = r2;
    while (((r1 && !got1) || (r2 && !got2)) && cyc < 40) begin
      tick();
      cyc++;
      if (bus.acc1_ack === 1'b1 || bus.acc2_ack === 1'b1) begin
        n++;
        if (n == 1) begin
          check("first_winner", 64'(bus.acc1_ack ? 1 : 2), 64'(first));
          check("first_ack_cycle", 64'(cyc), 64'd1);
        end else begin
          check("second_ack_cycle", 64'(cyc), 64'd4);
        end
      end
      if (bus.acc1_ack === 1'b1) begin
        got1 = 1'b1;
        bus.store_acc1 = 1'b0;
      end
      if (bus.acc2_ack === 1'b1) begin
        got2 = 1'b1;
        bus.store_acc2 = 1'b0;
      end
    end
    if (cyc >= 40) begin
      check("ack_timeout", 64'd0, 64'd1);
      bus.store_acc1 = 1'b0;
      bus.store_acc2 = 1'b0;
    end
    drain("serve");
  endtask

  initial begin
    bit seen;
    reset = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 1'b0, 32'hA, 32'hB, 32'h0, 32'h0, 1, 6'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 32'h1, 32'h2, 32'h3, 32'h4, 1, 6'd0};
    vecs[2] = '{1'b0, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 32'h8, 1, 6'd4};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 32'h9, 32'hA0, 32'h0, 32'h0, 1, 6'd8};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h11, 32'h12, 32'h13, 32'h14, 2, 6'd10};
    vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h15, 32'h16, 2, 6'd14};

    for (int i = 0; i < 6; i++) begin
      if (vecs[i].rst) do_reset();
      serve(vecs[i].r1, vecs[i].r2, vecs[i].a0, vecs[i].a1, vecs[i].b0, vecs[i].b1,
            vecs[i].first, vecs[i].addr);
      check("vec_words", 64'(bus.words_written),
            64'(vecs[i].addr) + 64'(2 * (int'(vecs[i].r1) + int'(vecs[i].r2))));
      check("vec_full", 64'(bus.ub_full), 64'd0);
    end

    // clear_ptr during WR0 at wptr=10: burst lands at 10/11, then pointer and count rewind.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      serve(1'b1, 1'b0, 32'h100 + 32'(2 * i), 32'h101 + 32'(2 * i), 32'h0, 32'h0, 1, 6'(2 * i));
    end
    push(6'd10, 32'hC0);
    push(6'd11, 32'hC1);
    bus.acc1_mem_0 = 32'hC0;
    bus.acc1_mem_1 = 32'hC1;
    bus.store_acc1 = 1'b1;
    tick();
    check("clr_wr0_ack", 64'(bus.acc1_ack), 64'd1);
    bus.store_acc1 = 1'b0;
    bus.clear_ptr  = 1'b1;
    tick();
    bus.clear_ptr  = 1'b0;
    tick();
    check("clr_wr0_words", 64'(bus.words_written), 64'd0);
    check("clr_wr0_drained", 64'(exp_q.size()), 64'd0);
    serve(1'b1, 1'b0, 32'hD0, 32'hD1, 32'h0, 32'h0, 1, 6'd0);
    check("clr_wr0_after_words", 64'(bus.words_written), 64'd2);

    // Fill to full, then a held request waits until a clear in IDLE lets it through at 0/1.
    do_reset();
    for (int i = 0; i < 32; i++) begin
      serve(1'b0, 1'b1, 32'h0, 32'h0, 32'h200 + 32'(2 * i), 32'h201 + 32'(2 * i), 2, 6'(2 * i));
    end
    check("fill_words", 64'(bus.words_written), 64'd64);
    check("fill_full", 64'(bus.ub_full), 64'd1);
    bus.acc2_mem_0 = 32'hE0;
    bus.acc2_mem_1 = 32'hE1;
    bus.store_acc2 = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      tick();
      if (bus.acc1_ack || bus.acc2_ack || bus.ub_wr_en) seen = 1'b1;
    end
    check("full_no_grant", 64'(seen), 64'd0);
    check("full_words_hold", 64'(bus.words_written), 64'd64);
    push(6'd0, 32'hE0);
    push(6'd1, 32'hE1);
    bus.clear_ptr = 1'b1;
    tick();
    check("full_clear_ack", 64'(bus.acc2_ack), 64'd1);
    bus.clear_ptr  = 1'b0;
    bus.store_acc2 = 1'b0;
    drain("full_clear");
    check("full_clear_words", 64'(bus.words_written), 64'd2);
    check("full_clear_notfull", 64'(bus.ub_full), 64'd0);

    // Reset in WR0 aborts the second write; the held request is re-granted at address 0.
    do_reset();
    push(6'd0, 32'hF0);
    bus.acc1_mem_0 = 32'hF0;
    bus.acc1_mem_1 = 32'hF1;
    bus.store_acc1 = 1'b1;
    tick();
    check("rst_mid_ack", 64'(bus.acc1_ack), 64'd1);
    reset = 1'b0;
    tick();
    check_zero_outputs("rst_mid");
    check("rst_mid_drained", 64'(exp_q.size()), 64'd0);
    push(6'd0, 32'hF0);
    push(6'd1, 32'hF1);
    reset = 1'b1;
    tick();
    check("rst_regrant_ack", 64'(bus.acc1_ack), 64'd1);
    bus.store_acc1 = 1'b0;
    drain("rst_regrant");
    check("rst_regrant_words", 64'(bus.words_written), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
